vme_cmd_master: RTL and testbench
=================================

# vme_cmd_master

Bus-cycle engine directly downstream of the simulation command-file handler. Accepts one decoded command word (address, read/write flag, write data) on a `start` pulse, runs a complete A24/D16 VME master cycle (AS/DS/WRITE strobes, DTACK/BERR wait) against the ODMB VME slave interface, and returns read data plus status. Its `vme_cmd_rd`/`vme_dat_wr` outputs pace the file handler: one command in flight at a time.

## Interface
Parameters:
- AS_SETUP, 2, cycles address/AM/WRITE are stable before AS asserts (min 1)
- DS_DELAY, 2, cycles from AS assert to DS assert (min 1)
- TIMEOUT, 1024, cycles waiting for DTACK/BERR before abort (only with VME_MASTER_TIMEOUT_EN)
- IDLE_GAP, 4, cycles after strobe release before next command accepted (min 0)
- AM_CODE, 6'h39, address modifier driven on every cycle

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command valid; sampled only while vme_cmd_rd=1
- vme_cmd_reg  in  32  [23:0] address, [24] write, [25] read
- vme_dat_reg_in  in  32  [15:0] write data
- vme_cmd_rd  out  1  ready for next command
- vme_dat_wr  out  1  one-cycle pulse: result on vme_dat_reg_out valid
- vme_dat_reg_out  out  32  [15:0] data, [29:16] 0, [30] bus error, [31] timeout
- vme_addr  out  24  VME address
- vme_am  out  6  address modifier
- vme_data_out  out  16  write data
- vme_data_oe  out  1  data bus drive enable (write cycles)
- vme_data_in  in  16  read data from slave
- vme_as_b  out  1  address strobe, active low
- vme_ds_b  out  2  data strobes, active low, both used (D16)
- vme_write_b  out  1  0=write, 1=read
- vme_dtack_b  in  1  asynchronous slave acknowledge, active low
- vme_berr_b  in  1  asynchronous bus error, active low

## Operation
- States: IDLE, SETUP, ASSERT_AS, ASSERT_DS, WAIT_ACK, RELEASE, GAP.
- IDLE: vme_cmd_rd=1. On start=1: bit25=1 → read; else bit24=1 → write; neither → command dropped, stay IDLE, no pulse. Both set → read. Latch address, data, direction; go SETUP.
- SETUP: drive vme_addr, vme_am, vme_write_b, (write) vme_data_out and vme_data_oe=1; count AS_SETUP → ASSERT_AS.
- ASSERT_AS: vme_as_b=0; count DS_DELAY → ASSERT_DS.
- ASSERT_DS: vme_ds_b=2'b00 → WAIT_ACK.
- WAIT_ACK: on synchronized dtack=0 capture vme_data_in (read) or latched write data (write) into [15:0]; on synchronized berr=0 set [30], data 0; dtack and berr same cycle → berr wins. On timeout set [31], data 0. Any of the three → RELEASE, vme_dat_wr=1 for that one cycle.
- RELEASE: as_b, ds_b high, data_oe=0; wait synchronized dtack=1 and berr=1 (skipped after timeout) → GAP.
- GAP: count IDLE_GAP → IDLE.
- start while not IDLE ignored. vme_dat_reg_out holds until next result.

## Timing
- Reset values: vme_cmd_rd=1, vme_dat_wr=0, vme_dat_reg_out=0, vme_addr=0, vme_am=0, vme_data_out=0, vme_data_oe=0, vme_as_b=1, vme_ds_b=2'b11, vme_write_b=1; state IDLE.
- Reset mid-cycle releases all strobes and data_oe immediately (asynchronous); no vme_dat_wr.
- start sampled edge N → vme_cmd_rd=0 and address valid from N+1; AS low at N+1+AS_SETUP; DS low DS_DELAY later.
- dtack/berr through 2-flop synchronizer: result pulse 3 cycles after DTACK falls (sync 2 + register 1).
- All outputs registered; vme_cmd_rd returns high IDLE_GAP+1 cycles after strobe release completes.
- Timeout counter starts at ASSERT_DS entry, fires after exactly TIMEOUT cycles in WAIT_ACK.

## Configuration
- VME_MASTER_TIMEOUT_EN defined: timeout counter present, [31] settable, abort as above.
- Undefined: no counter, WAIT_ACK waits indefinitely, [31] constant 0, TIMEOUT unused.

## Structure
- Package vme_master_pkg: state enum, status bit indices (STAT_BERR=30, STAT_TMO=31), command bit indices (CMD_WR=24, CMD_RD=25), AM constants.
- Sub-module vme_sync2: 2-flop synchronizer, async reset to 1, instantiated for dtack_b and berr_b.

## Test plan
- Write 0x00A81234 cmd bit24, data 0x5A5A, slave DTACK after 5 cycles → write_b=0, data_out=0x5A5A, oe=1 during cycle, vme_dat_wr pulse, [15:0]=0x5A5A, [31:30]=0.
- Read 0x00A80000 bit25, slave returns 0xBEEF → vme_dat_reg_out=0x0000BEEF, write_b=1, oe=0.
- Command with bits 24/25 both 0 → no AS, no pulse, vme_cmd_rd stays 1.
- No DTACK (macro on, TIMEOUT=16) → pulse 16 cycles after DS, output 0x80000000, strobes released; macro off → no pulse ever.
- BERR and DTACK same cycle → output 0x40000000.
- rst asserted during ASSERT_DS → as_b, ds_b high same cycle, vme_cmd_rd=1, no pulse; next command runs normally.

Source files
------------

// File: rtl/vme_master_pkg.sv
// Shared definitions for the VME A24/D16 command master: FSM state encoding,
// command/status bit positions and address-modifier constants.
package vme_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ASSERT_AS = 3'd2,
        ST_ASSERT_DS = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_RELEASE   = 3'd5,
        ST_GAP       = 3'd6
    } vme_state_t;

    // Command word fields
    localparam int CMD_ADDR_W = 24;
    localparam int CMD_WR     = 24;
    localparam int CMD_RD     = 25;

    // Result word status bits
    localparam int STAT_BERR  = 30;
    localparam int STAT_TMO   = 31;

    // A24 address modifiers
    localparam logic [5:0] AM_A24_USR_DATA = 6'h39;
    localparam logic [5:0] AM_A24_SUP_DATA = 6'h3D;

    // Width of the shared setup/delay/gap phase counter
    localparam int CNT_W = 16;

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchronizer for asynchronous active-low VME handshake lines.
// Resets to 1 so a released (deasserted) line is seen out of reset.
module vme_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/vme_cmd_master.sv
// VME A24/D16 master bus-cycle engine. Takes one command word on start,
// runs a full AS/DS/DTACK handshake and returns data plus status.
// Optional feature macro: VME_MASTER_TIMEOUT_EN (DTACK/BERR wait timeout).
module vme_cmd_master
    import vme_master_pkg::*;
#(
    parameter int         AS_SETUP = 2,
    parameter int         DS_DELAY = 2,
    parameter int         TIMEOUT  = 1024,
    parameter int         IDLE_GAP = 4,
    parameter logic [5:0] AM_CODE  = AM_A24_USR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [23:0] vme_addr,
    output logic [5:0]  vme_am,
    output logic [15:0] vme_data_out,
    output logic        vme_data_oe,
    input  logic [15:0] vme_data_in,
    output logic        vme_as_b,
    output logic [1:0]  vme_ds_b,
    output logic        vme_write_b,
    input  logic        vme_dtack_b,
    input  logic        vme_berr_b
);

    // ------------------------------------------------------------------
    // Handshake synchronizers: index 0 = DTACK, index 1 = BERR
    // ------------------------------------------------------------------
    logic [1:0] hs_raw;
    logic [1:0] hs_sync;
    logic       dtack_sync_b;
    logic       berr_sync_b;

    assign hs_raw = {vme_berr_b, vme_dtack_b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hs_sync
            vme_sync2 u_sync (
                .clk (clk),
                .rst (rst),
                .d   (hs_raw[gi]),
                .q   (hs_sync[gi])
            );
        end
    endgenerate

    assign dtack_sync_b = hs_sync[0];
    assign berr_sync_b  = hs_sync[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    vme_state_t          state_reg,     state_next;
    logic [CNT_W-1:0]    cnt_reg,       cnt_next;
    logic                is_write_reg,  is_write_next;
    logic                tmo_flag_reg,  tmo_flag_next;
    logic                cmd_rd_reg,    cmd_rd_next;
    logic                dat_wr_reg,    dat_wr_next;
    logic [31:0]         dat_out_reg,   dat_out_next;
    logic [23:0]         addr_reg,      addr_next;
    logic [5:0]          am_reg,        am_next;
    logic [15:0]         data_out_reg,  data_out_next;
    logic                data_oe_reg,   data_oe_next;
    logic                as_b_reg,      as_b_next;
    logic [1:0]          ds_b_reg,      ds_b_next;
    logic                write_b_reg,   write_b_next;

    logic                tmo_hit;
    logic                cmd_valid;
    logic                cmd_is_read;

    // Upper command/data bits carry nothing for an A24/D16 cycle
    logic                unused_bits;
    assign unused_bits = &{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

    assign cmd_is_read = vme_cmd_reg[CMD_RD];
    assign cmd_valid   = vme_cmd_reg[CMD_RD] | vme_cmd_reg[CMD_WR];

    // ------------------------------------------------------------------
    // Optional DTACK/BERR wait timeout
    // ------------------------------------------------------------------
`ifdef VME_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;

    // Cleared while AS is low, runs from DS assertion through the ack wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_ASSERT_AS) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_ASSERT_DS || state_reg == ST_WAIT_ACK) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    assign tmo_hit = (state_reg == ST_WAIT_ACK) &&
                     (tmo_cnt_reg >= TMO_W'(TIMEOUT - 1));
`else
    // No timeout logic: the wait is unbounded. The legality test on
    // TIMEOUT folds to 0 and keeps the parameter referenced in this build.
    assign tmo_hit = (TIMEOUT < 1);
`endif

    // ------------------------------------------------------------------
    // Register update for FSM state and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            is_write_reg <= 1'b0;
            tmo_flag_reg <= 1'b0;
            cmd_rd_reg   <= 1'b1;
            dat_wr_reg   <= 1'b0;
            dat_out_reg  <= '0;
            addr_reg     <= '0;
            am_reg       <= '0;
            data_out_reg <= '0;
            data_oe_reg  <= 1'b0;
            as_b_reg     <= 1'b1;
            ds_b_reg     <= 2'b11;
            write_b_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            is_write_reg <= is_write_next;
            tmo_flag_reg <= tmo_flag_next;
            cmd_rd_reg   <= cmd_rd_next;
            dat_wr_reg   <= dat_wr_next;
            dat_out_reg  <= dat_out_next;
            addr_reg     <= addr_next;
            am_reg       <= am_next;
            data_out_reg <= data_out_next;
            data_oe_reg  <= data_oe_next;
            as_b_reg     <= as_b_next;
            ds_b_reg     <= ds_b_next;
            write_b_reg  <= write_b_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic; outputs change on the same edge
    // as the state they belong to, so every pin is a flop output
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        is_write_next = is_write_reg;
        tmo_flag_next = tmo_flag_reg;
        cmd_rd_next   = cmd_rd_reg;
        dat_wr_next   = 1'b0;
        dat_out_next  = dat_out_reg;
        addr_next     = addr_reg;
        am_next       = am_reg;
        data_out_next = data_out_reg;
        data_oe_next  = data_oe_reg;
        as_b_next     = as_b_reg;
        ds_b_next     = ds_b_reg;
        write_b_next  = write_b_reg;

        case (state_reg)
            ST_IDLE: begin
                cmd_rd_next = 1'b1;
                // Commands with neither direction bit are silently dropped
                if (start && cmd_valid) begin
                    is_write_next = ~cmd_is_read;
                    tmo_flag_next = 1'b0;
                    addr_next     = vme_cmd_reg[CMD_ADDR_W-1:0];
                    am_next       = AM_CODE;
                    write_b_next  = cmd_is_read;
                    if (!cmd_is_read) begin
                        data_out_next = vme_dat_reg_in[15:0];
                        data_oe_next  = 1'b1;
                    end
                    cmd_rd_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_reg >= CNT_W'(AS_SETUP - 1)) begin
                    as_b_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_ASSERT_AS;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_ASSERT_AS: begin
                if (cnt_reg >= CNT_W'(DS_DELAY - 1)) begin
                    ds_b_next  = 2'b00;
                    cnt_next   = '0;
                    state_next = ST_ASSERT_DS;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_ASSERT_DS: begin
                state_next = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                // BERR has priority over DTACK; a real response beats timeout
                if (!berr_sync_b || !dtack_sync_b || tmo_hit) begin
                    dat_out_next = '0;
                    if (!berr_sync_b) begin
                        dat_out_next[STAT_BERR] = 1'b1;
                    end else if (!dtack_sync_b) begin
                        dat_out_next[15:0] = is_write_reg ? data_out_reg : vme_data_in;
                    end else begin
                        dat_out_next[STAT_TMO] = 1'b1;
                        tmo_flag_next          = 1'b1;
                    end
                    dat_wr_next  = 1'b1;
                    as_b_next    = 1'b1;
                    ds_b_next    = 2'b11;
                    data_oe_next = 1'b0;
                    state_next   = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // A timed-out slave may never release, so don't wait on it
                if (tmo_flag_reg || (dtack_sync_b && berr_sync_b)) begin
                    write_b_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (cnt_reg >= CNT_W'(IDLE_GAP)) begin
                    cmd_rd_next = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                as_b_next    = 1'b1;
                ds_b_next    = 2'b11;
                data_oe_next = 1'b0;
                write_b_next = 1'b1;
                cmd_rd_next  = 1'b1;
                state_next   = ST_IDLE;
            end
        endcase
    end

    assign vme_cmd_rd      = cmd_rd_reg;
    assign vme_dat_wr      = dat_wr_reg;
    assign vme_dat_reg_out = dat_out_reg;
    assign vme_addr        = addr_reg;
    assign vme_am          = am_reg;
    assign vme_data_out    = data_out_reg;
    assign vme_data_oe     = data_oe_reg;
    assign vme_as_b        = as_b_reg;
    assign vme_ds_b        = ds_b_reg;
    assign vme_write_b     = write_b_reg;

endmodule

// File: tb/tb_vme_cmd_master.sv
// Scoreboard bench for vme_cmd_master: expected result words are queued as
// commands are issued and compared when the DUT pulses vme_dat_wr.
module tb_vme_cmd_master;

    localparam int AS_SETUP = 2;
    localparam int DS_DELAY = 2;
    localparam int TIMEOUT  = 16;
    localparam int IDLE_GAP = 4;

    localparam int M_ACK      = 0;
    localparam int M_BERR_ACK = 1;
    localparam int M_NONE     = 2;
    localparam int M_RESET    = 3;
    localparam int M_BERR     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vme_cmd_reg = '0;
    logic [31:0] vme_dat_reg_in = '0;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [23:0] vme_addr;
    logic [5:0]  vme_am;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in = 16'hDEAD;
    logic        vme_as_b;
    logic [1:0]  vme_ds_b;
    logic        vme_write_b;
    logic        vme_dtack_b = 1'b1;
    logic        vme_berr_b = 1'b1;

    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          exp_pulses = 0;

    vme_cmd_master #(
        .AS_SETUP (AS_SETUP),
        .DS_DELAY (DS_DELAY),
        .TIMEOUT  (TIMEOUT),
        .IDLE_GAP (IDLE_GAP),
        .AM_CODE  (6'h39)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out),
        .vme_addr        (vme_addr),
        .vme_am          (vme_am),
        .vme_data_out    (vme_data_out),
        .vme_data_oe     (vme_data_oe),
        .vme_data_in     (vme_data_in),
        .vme_as_b        (vme_as_b),
        .vme_ds_b        (vme_ds_b),
        .vme_write_b     (vme_write_b),
        .vme_dtack_b     (vme_dtack_b),
        .vme_berr_b      (vme_berr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Result monitor: every vme_dat_wr pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && vme_dat_wr) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                $display("txn result=0x%08h expected=0x%08h", vme_dat_reg_out, exp_word);
                check("result", vme_dat_reg_out, exp_word);
            end
        end
    end

    // Issue one command and act as the slave for its bus cycle
    task automatic run_cmd(input logic [31:0] cmd, input logic [15:0] wdata, input int mode,
                           input int delay, input logic [15:0] rdata, input logic [31:0] exp);
        bit runs;
        bit is_wr;
        bit seen;
        bit is_tmo;
        int k;
        runs   = cmd[25] | cmd[24];
        is_wr  = !cmd[25] && cmd[24];
        is_tmo = 1'b0;

        k = 0;
        while (!vme_cmd_rd && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cmd_rd_ready", {31'd0, vme_cmd_rd}, 32'd1);

        if (runs && mode != M_RESET) begin
            exp_q.push_back(exp);
            exp_pulses++;
        end

        start          = 1'b1;
        vme_cmd_reg    = cmd;
        vme_dat_reg_in = {16'hFFFF, wdata};
        @(negedge clk);
        start = 1'b0;
        check("cmd_rd_after_start", {31'd0, vme_cmd_rd}, {31'd0, !runs});

        if (!runs) begin
            seen = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (!vme_as_b || !vme_cmd_rd) seen = 1'b1;
            end
            $display("txn cmd=0x%08h dropped", cmd);
            check("dropped_cmd_quiet", {31'd0, seen}, 32'd0);
            return;
        end

        check("addr_setup", {8'd0, vme_addr}, {8'd0, cmd[23:0]});
        check("am", {26'd0, vme_am}, 32'h39);

        // A second command offered mid-cycle must be ignored
        start          = 1'b1;
        vme_cmd_reg    = 32'h01FF_FFFF;
        vme_dat_reg_in = 32'h0000_1111;
        k = 0;
        while (vme_as_b && k < 50) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("as_setup_cycles", k, AS_SETUP);
        k = 0;
        while (vme_ds_b == 2'b11 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ds_delay_cycles", k, DS_DELAY);
        check("ds_both_low", {30'd0, vme_ds_b}, 32'd0);
        check("addr_hold", {8'd0, vme_addr}, {8'd0, cmd[23:0]});
        check("write_b", {31'd0, vme_write_b}, {31'd0, !is_wr});
        check("data_oe", {31'd0, vme_data_oe}, {31'd0, is_wr});
        if (is_wr) check("data_out", {16'd0, vme_data_out}, {16'd0, wdata});

        case (mode)
            M_RESET: begin
                #1 rst = 1'b1;
                #1;
                check("rst_as_b", {31'd0, vme_as_b}, 32'd1);
                check("rst_ds_b", {30'd0, vme_ds_b}, 32'd3);
                check("rst_oe", {31'd0, vme_data_oe}, 32'd0);
                check("rst_cmd_rd", {31'd0, vme_cmd_rd}, 32'd1);
                check("rst_dat_wr", {31'd0, vme_dat_wr}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                $display("txn cmd=0x%08h aborted by reset", cmd);
                check("rst_out_cleared", vme_dat_reg_out, 32'd0);
                return;
            end
            M_NONE: begin
`ifdef VME_MASTER_TIMEOUT_EN
                is_tmo = 1'b1;
                k = 0;
                while (!vme_dat_wr && k < TIMEOUT + 50) begin
                    @(negedge clk);
                    k++;
                end
                check("timeout_cycles", k, TIMEOUT);
`else
                seen = 1'b0;
                repeat (TIMEOUT * 4) begin
                    @(negedge clk);
                    if (vme_dat_wr) seen = 1'b1;
                end
                check("no_timeout_pulse", {31'd0, seen}, 32'd0);
                check("as_still_low", {31'd0, vme_as_b}, 32'd0);
                vme_data_in = rdata;
                vme_dtack_b = 1'b0;
                k = 0;
                while (!vme_dat_wr && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                check("ack_to_pulse", k, 3);
`endif
            end
            default: begin
                repeat (delay) @(negedge clk);
                vme_data_in = rdata;
                if (mode != M_BERR) vme_dtack_b = 1'b0;
                if (mode != M_ACK) vme_berr_b = 1'b0;
                k = 0;
                while (!vme_dat_wr && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                check("ack_to_pulse", k, 3);
            end
        endcase

        check("as_released", {31'd0, vme_as_b}, 32'd1);
        check("ds_released", {30'd0, vme_ds_b}, 32'd3);
        check("oe_released", {31'd0, vme_data_oe}, 32'd0);

        vme_dtack_b = 1'b1;
        vme_berr_b  = 1'b1;
        vme_data_in = 16'hDEAD;
        k = 0;
        while (!vme_cmd_rd && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (is_tmo) check("gap_after_timeout", k, IDLE_GAP + 2);
        else check("cmd_rd_returns", {31'd0, k < 100}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rcmd;
        logic [15:0] rdat;

        repeat (3) @(negedge clk);
        check("rst_cmd_rd_init", {31'd0, vme_cmd_rd}, 32'd1);
        check("rst_dat_wr_init", {31'd0, vme_dat_wr}, 32'd0);
        check("rst_dat_out_init", vme_dat_reg_out, 32'd0);
        check("rst_addr_init", {8'd0, vme_addr}, 32'd0);
        check("rst_am_init", {26'd0, vme_am}, 32'd0);
        check("rst_data_out_init", {16'd0, vme_data_out}, 32'd0);
        check("rst_oe_init", {31'd0, vme_data_oe}, 32'd0);
        check("rst_as_init", {31'd0, vme_as_b}, 32'd1);
        check("rst_ds_init", {30'd0, vme_ds_b}, 32'd3);
        check("rst_write_b_init", {31'd0, vme_write_b}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write: result carries the latched write data, not the data bus
        run_cmd(32'h01A8_1234, 16'h5A5A, M_ACK, 5, 16'hDEAD, 32'h0000_5A5A);
        // Read
        run_cmd(32'h02A8_0000, 16'h0000, M_ACK, 2, 16'hBEEF, 32'h0000_BEEF);
        // Neither direction bit: dropped
        run_cmd(32'h00A8_0000, 16'h0000, M_ACK, 0, 16'h0000, 32'h0);
        // Both direction bits: treated as read
        run_cmd(32'h03A8_0010, 16'h7777, M_ACK, 1, 16'h1357, 32'h0000_1357);
        // BERR together with DTACK: BERR wins
        run_cmd(32'h02A8_0020, 16'h0000, M_BERR_ACK, 3, 16'hAAAA, 32'h4000_0000);
        // BERR alone on a write
        run_cmd(32'h0100_0100, 16'h0F0F, M_BERR, 0, 16'hDEAD, 32'h4000_0000);
        // No response at all
`ifdef VME_MASTER_TIMEOUT_EN
        run_cmd(32'h02A8_0040, 16'h0000, M_NONE, 0, 16'h4242, 32'h8000_0000);
`else
        run_cmd(32'h02A8_0040, 16'h0000, M_NONE, 0, 16'h4242, 32'h0000_4242);
`endif
        // Reset while DS is being asserted, then a normal command
        run_cmd(32'h02A8_0080, 16'h0000, M_RESET, 0, 16'h0000, 32'h0);
        run_cmd(32'h0100_0002, 16'hC3C3, M_ACK, 0, 16'hDEAD, 32'h0000_C3C3);

        // Mixed random reads and writes
        for (int i = 0; i < 6; i++) begin
            rdat = 16'($urandom);
            rcmd = {8'd0, 24'($urandom)};
            if (i % 2 == 0) begin
                rcmd[25] = 1'b1;
                run_cmd(rcmd, 16'h0000, M_ACK, int'($urandom_range(0, 6)), rdat, {16'd0, rdat});
            end else begin
                rcmd[24] = 1'b1;
                run_cmd(rcmd, rdat, M_ACK, int'($urandom_range(0, 6)), 16'hDEAD, {16'd0, rdat});
            end
        end

        repeat (10) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        check("pulse_count", pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
